// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and op classification.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle.
module alu_muldiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] ma,
  input  logic [WIDTH-1:0] mb,
  output logic             last_c,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             run;
  logic             div_mode;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   acc_sum;
  logic             rem_ge;

  // res_hi is accumulator (mult) or partial remainder (div); res_lo is multiplier or dividend/quotient
  always_comb begin
    rem_sh   = {res_hi, res_lo[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, divisor};
    rem_diff = rem_sh[WIDTH-1:0] - divisor;
    acc_sum  = {1'b0, res_hi} + (res_lo[0] ? {1'b0, divisor} : '0);
    if (div_mode) begin
      step_hi = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
      step_lo = {res_lo[WIDTH-2:0], rem_ge};
    end else begin
      step_hi = acc_sum[WIDTH:1];
      step_lo = {acc_sum[0], res_lo[WIDTH-1:1]};
    end
  end

  assign last_c = run && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      run      <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
      divisor  <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
    end else if (start) begin
      run      <= 1'b1;
      div_mode <= mode;
      cnt      <= '0;
      divisor  <= mb;
      res_hi   <= '0;
      res_lo   <= ma;
    end else if (run) begin
      res_hi <= step_hi;
      res_lo <= step_lo;
      cnt    <= cnt + CW'(1);
      if (last_c) begin
        run <= 1'b0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-cycle logic/arith ops plus iterative mult/div with valid/busy/done handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             unsig,
  output logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] hi,
  output logic             compout,
  output logic             overflow,
  output logic             divz,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;
  logic   accept, start;

  logic             a_neg, b_neg, lt_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic             pend_valid, p_unsig;
  logic [WIDTH-1:0] p_a, p_b;
  logic [3:0]       p_op;
  logic [WIDTH-1:0] s_lo, s_sum, s_dif;
  logic             s_cmp, s_ovf;

  logic             md_div, md_neg_lo, md_neg_hi, md_ovf, md_divz, md_cmp;
  logic [WIDTH-1:0] md_a;
  logic             core_last;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fix_lo, fix_hi;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (is_muldiv(op)) begin
            start     = 1'b1;
            state_nxt = ST_CALC;
          end
        end
      end
      ST_CALC: if (core_last) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // operand magnitudes and compare on the request as presented
  always_comb begin
    a_neg = !unsig && a[WIDTH-1];
    b_neg = !unsig && b[WIDTH-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
    lt_in = unsig ? (a < b) : ($signed(a) < $signed(b));
  end

  // simple ops are evaluated from the staged request one cycle after accept
  always_comb begin
    s_cmp = p_unsig ? (p_a < p_b) : ($signed(p_a) < $signed(p_b));
    s_sum = p_a + p_b;
    s_dif = p_a - p_b;
    s_lo  = '0;
    s_ovf = 1'b0;
    case (p_op)
      OP_AND: s_lo = p_a & p_b;
      OP_OR:  s_lo = p_a | p_b;
      OP_NOR: s_lo = ~(p_a | p_b);
      OP_XOR: s_lo = p_a ^ p_b;
      OP_ADD: begin
        s_lo  = s_sum;
        s_ovf = !p_unsig && (p_a[WIDTH-1] == p_b[WIDTH-1]) && (s_sum[WIDTH-1] != p_a[WIDTH-1]);
      end
      OP_SUB: begin
        s_lo  = s_dif;
        s_ovf = !p_unsig && (p_a[WIDTH-1] != p_b[WIDTH-1]) && (s_dif[WIDTH-1] != p_a[WIDTH-1]);
      end
      OP_SLT: s_lo = WIDTH'(s_cmp);
      default: s_lo = '0;
    endcase
  end

  // sign correction of the unsigned engine result
  always_comb begin
    prod = {core_hi, core_lo};
    if (md_neg_lo) prod = -prod;
    fix_lo = prod[WIDTH-1:0];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    if (md_div) begin
      fix_lo = md_neg_lo ? -core_lo : core_lo;
      fix_hi = md_neg_hi ? -core_hi : core_hi;
      if (md_divz) begin
        fix_lo = '1;
        fix_hi = md_a;
      end
    end
  end

  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .mode   (op == OP_DIV),
    .ma     (mag_a),
    .mb     (mag_b),
    .last_c (core_last),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= 1'b0;
      p_a        <= '0;
      p_b        <= '0;
      p_op       <= '0;
      p_unsig    <= 1'b0;
      md_div     <= 1'b0;
      md_neg_lo  <= 1'b0;
      md_neg_hi  <= 1'b0;
      md_ovf     <= 1'b0;
      md_divz    <= 1'b0;
      md_cmp     <= 1'b0;
      md_a       <= '0;
      aluout     <= '0;
      hi         <= '0;
      compout    <= 1'b0;
      overflow   <= 1'b0;
      divz       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      busy       <= (state_nxt != ST_IDLE);
      pend_valid <= accept && !start;
      if (accept && !start) begin
        p_a     <= a;
        p_b     <= b;
        p_op    <= op;
        p_unsig <= unsig;
      end
      if (start) begin
        md_div    <= (op == OP_DIV);
        md_neg_lo <= a_neg ^ b_neg;
        md_neg_hi <= (op == OP_DIV) ? a_neg : (a_neg ^ b_neg);
        md_ovf    <= (op == OP_DIV) && !unsig && (a == MIN_VAL) && (b == '1);
        md_divz   <= (op == OP_DIV) && (b == '0);
        md_cmp    <= lt_in;
        md_a      <= a;
      end
      if (pend_valid) begin
        aluout   <= s_lo;
        hi       <= '0;
        compout  <= s_cmp;
        overflow <= s_ovf;
        divz     <= 1'b0;
        done     <= 1'b1;
      end else if (state == ST_FIX) begin
        aluout   <= fix_lo;
        hi       <= fix_hi;
        compout  <= md_cmp;
        overflow <= md_ovf;
        divz     <= md_divz;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_mc;
  import alu_pkg::*;

  int checks = 0;
  int failures = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        v32 = 1'b0, u32 = 1'b0;
  logic [3:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, aluout32, hi32;
  logic        cmp32, ovf32, dz32, busy32, done32;

  logic        v8 = 1'b0, u8 = 1'b0;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, aluout8, hi8;
  logic        cmp8, ovf8, dz8, busy8, done8;

  logic [3:0] op_pool [11] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd3, 4'd15};

  always #5 clock = ~clock;

  alu_mc #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .in_valid(v32), .a(a32), .b(b32), .op(op32), .unsig(u32),
    .aluout(aluout32), .hi(hi32), .compout(cmp32), .overflow(ovf32), .divz(dz32),
    .busy(busy32), .done(done32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(v8), .a(a8), .b(b8), .op(op8), .unsig(u8),
    .aluout(aluout8), .hi(hi8), .compout(cmp8), .overflow(ovf8), .divz(dz8),
    .busy(busy8), .done(done8)
  );

  // Reference: values interpreted as integers, results reduced modulo 2^w
  function automatic logic [66:0] model(input int w, input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic u);
    longint m, mn, mx, av, bv, r;
    logic [63:0] p;
    logic [31:0] lo, hv, m32;
    logic cmp, ovf, dz;
    m   = (longint'(1) << w) - 1;
    m32 = 32'(m);
    mn  = -(longint'(1) << (w - 1));
    mx  = -mn - 1;
    av  = longint'(x & m32);
    bv  = longint'(y & m32);
    if (!u && av > mx) av = av - (m + 1);
    if (!u && bv > mx) bv = bv - (m + 1);
    cmp = (av < bv);
    ovf = 1'b0; dz = 1'b0; lo = '0; hv = '0;
    case (o)
      OP_AND: lo = x & y & m32;
      OP_OR:  lo = (x | y) & m32;
      OP_NOR: lo = ~(x | y) & m32;
      OP_XOR: lo = (x ^ y) & m32;
      OP_ADD: begin r = av + bv; lo = 32'(r & m); ovf = !u && (r > mx || r < mn); end
      OP_SUB: begin r = av - bv; lo = 32'(r & m); ovf = !u && (r > mx || r < mn); end
      OP_SLT: lo = 32'(cmp);
      OP_MULT: begin
        p  = 64'(av * bv);
        lo = 32'(p & 64'(m));
        hv = 32'((p >> w) & 64'(m));
      end
      OP_DIV: begin
        if (bv == 0) begin
          dz = 1'b1; lo = m32; hv = x & m32;
        end else if (!u && av == mn && bv == -1) begin
          lo = 32'(mn & m); hv = '0; ovf = 1'b1;
        end else begin
          lo = 32'((av / bv) & m);
          hv = 32'((av % bv) & m);
        end
      end
      default: lo = '0;
    endcase
    return {lo, hv, cmp, ovf, dz};
  endfunction

  function automatic logic [66:0] obs_of(input bit s8);
    if (s8) return {24'b0, aluout8, 24'b0, hi8, cmp8, ovf8, dz8};
    return {aluout32, hi32, cmp32, ovf32, dz32};
  endfunction

  function automatic logic done_of(input bit s8);
    return s8 ? done8 : done32;
  endfunction

  function automatic logic busy_of(input bit s8);
    return s8 ? busy8 : busy32;
  endfunction

  function automatic logic [31:0] rnd_val(input bit s8);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return s8 ? 32'h80 : 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input bit s8, input logic v, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic u);
    if (s8) begin
      v8 = v; op8 = o; a8 = x[7:0]; b8 = y[7:0]; u8 = u;
    end else begin
      v32 = v; op32 = o; a32 = x; b32 = y; u32 = u;
    end
  endtask

  // present one request, wait (bounded) for done; lat = edges after accept, -1 on timeout
  task automatic issue(input bit s8, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic u, output int lat, output logic [66:0] res, output bit gap);
    lat = -1;
    gap = 1'b0;
    @(negedge clock);
    drive(s8, 1'b1, o, x, y, u);
    @(posedge clock);
    @(negedge clock);
    drive(s8, 1'b0, o, x, y, u);
    if (done_of(s8)) lat = 0;
    for (int i = 1; i <= 80 && lat < 0; i++) begin
      if (is_muldiv(o) && !busy_of(s8)) gap = 1'b1;
      @(posedge clock);
      @(negedge clock);
      if (done_of(s8)) lat = i;
    end
    res = obs_of(s8);
  endtask

  task automatic test_reset;
    bit seen;
    reset = 1'b1;
    drive(0, 1'b1, OP_ADD, 32'd5, 32'd6, 1'b0);
    drive(1, 1'b1, OP_ADD, 32'd5, 32'd6, 1'b0);
    repeat (3) @(negedge clock);
    checks++;
    if ({aluout32, hi32, cmp32, ovf32, dz32, busy32, done32} !== '0) begin
      failures++;
      $display("FAIL reset_state32 got=%h/%h flags=%b%b%b%b%b want all zero",
               aluout32, hi32, cmp32, ovf32, dz32, busy32, done32);
    end
    checks++;
    if ({aluout8, hi8, cmp8, ovf8, dz8, busy8, done8} !== '0) begin
      failures++;
      $display("FAIL reset_state8 got=%h/%h flags=%b%b%b%b%b want all zero",
               aluout8, hi8, cmp8, ovf8, dz8, busy8, done8);
    end
    reset = 1'b0;
    drive(0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clock);
      @(negedge clock);
      if (done32 || done8) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_drops_request got done=%b want 0", seen);
    end
  endtask

  task automatic test_addsub;
    logic [3:0]  t_op [4] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB};
    logic [31:0] t_a  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF};
    logic [31:0] t_b  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF};
    logic        t_u  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [66:0] res, exp;
    bit gap;
    for (int i = 0; i < 4; i++) begin
      issue(0, t_op[i], t_a[i], t_b[i], t_u[i], lat, res, gap);
      exp = model(32, t_op[i], t_a[i], t_b[i], t_u[i]);
      checks++;
      if (res !== exp) begin
        failures++;
        $display("FAIL addsub[%0d] got=%h want=%h", i, res, exp);
      end
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("FAIL addsub_latency[%0d] got=%0d want=1", i, lat);
      end
    end
  endtask

  task automatic test_muldiv;
    bit          t_s8 [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  t_op [5] = '{OP_MULT, OP_DIV, OP_DIV, OP_DIV, OP_DIV};
    logic [31:0] t_a  [5] = '{32'hFFFF_FFFD, 32'hF9, 32'hF9, 32'h80, 32'h100};
    logic [31:0] t_b  [5] = '{32'h7, 32'h2, 32'h0, 32'hFF, 32'h7};
    logic        t_u  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    logic [66:0] res, exp;
    bit gap;
    for (int i = 0; i < 5; i++) begin
      issue(t_s8[i], t_op[i], t_a[i], t_b[i], t_u[i], lat, res, gap);
      exp = model(t_s8[i] ? 8 : 32, t_op[i], t_a[i], t_b[i], t_u[i]);
      checks++;
      if (res !== exp) begin
        failures++;
        $display("FAIL muldiv[%0d] got=%h want=%h", i, res, exp);
      end
      checks++;
      if (lat !== (t_s8[i] ? 9 : 33)) begin
        failures++;
        $display("FAIL muldiv_latency[%0d] got=%0d want=%0d", i, lat, t_s8[i] ? 9 : 33);
      end
      checks++;
      if (gap !== 1'b0) begin
        failures++;
        $display("FAIL muldiv_busy[%0d] got busy gap=%b want 0", i, gap);
      end
    end
  endtask

  task automatic test_busy_drop;
    int lat;
    bit busy_ok, seen;
    logic [66:0] exp, held;
    exp = model(32, OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    @(negedge clock);
    drive(0, 1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    @(posedge clock);
    @(negedge clock);
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      if (!busy32) busy_ok = 1'b0;
      if (i == 6) drive(0, 1'b1, OP_ADD, 32'd1, 32'd2, 1'b0);
      else        drive(0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
      @(posedge clock);
      @(negedge clock);
      if (done32) lat = i;
    end
    drive(0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL busy_drop_latency got=%0d want=33", lat);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      failures++;
      $display("FAIL busy_drop_busy got busy_ok=%b want 1", busy_ok);
    end
    checks++;
    if (obs_of(0) !== exp) begin
      failures++;
      $display("FAIL busy_drop_result got=%h want=%h", obs_of(0), exp);
    end
    seen = 1'b0;
    held = exp;
    repeat (4) begin
      @(posedge clock);
      @(negedge clock);
      if (done32) seen = 1'b1;
      if (obs_of(0) !== exp) held = obs_of(0);
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL busy_drop_no_extra_done got=%b want 0", seen);
    end
    checks++;
    if (held !== exp) begin
      failures++;
      $display("FAIL busy_drop_hold got=%h want=%h", held, exp);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    int lat;
    logic [66:0] res, exp;
    bit gap;
    @(negedge clock);
    drive(0, 1'b1, OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    @(posedge clock);
    @(negedge clock);
    drive(0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clock);
      @(negedge clock);
      if (done32) seen = 1'b1;
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({aluout32, hi32, cmp32, ovf32, dz32, busy32, done32} !== '0) begin
      failures++;
      $display("FAIL reset_mid_state got=%h/%h flags=%b%b%b%b%b want all zero",
               aluout32, hi32, cmp32, ovf32, dz32, busy32, done32);
    end
    reset = 1'b0;
    repeat (40) begin
      @(posedge clock);
      @(negedge clock);
      if (done32) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_done got=%b want 0", seen);
    end
    issue(0, OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, lat, res, gap);
    exp = model(32, OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
    checks++;
    if (res !== exp || lat !== 1) begin
      failures++;
      $display("FAIL reset_mid_after_and got=%h lat=%0d want=%h lat=1", res, lat, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [66:0] expq [$];
    logic [66:0] exp, last;
    logic [3:0] o;
    logic [31:0] x, y;
    logic u;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      o = op_pool[$urandom_range(0, 6)];
      x = $urandom;
      y = $urandom;
      u = 1'($urandom_range(0, 1));
      drive(0, 1'b1, o, x, y, u);
      expq.push_back(model(32, o, x, y, u));
      @(posedge clock);
      @(negedge clock);
      if (i > 0) begin
        exp = expq.pop_front();
        checks++;
        if (done32 !== 1'b1 || obs_of(0) !== exp) begin
          failures++;
          $display("FAIL b2b[%0d] done=%b got=%h want=%h", i - 1, done32, obs_of(0), exp);
        end
      end
    end
    drive(0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    last = expq.pop_front();
    checks++;
    if (done32 !== 1'b1 || obs_of(0) !== last) begin
      failures++;
      $display("FAIL b2b_last done=%b got=%h want=%h", done32, obs_of(0), last);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (done32 !== 1'b0 || obs_of(0) !== last) begin
        failures++;
        $display("FAIL b2b_hold[%0d] done=%b got=%h want=%h", i, done32, obs_of(0), last);
      end
    end
  endtask

  task automatic test_random;
    bit s8, gap;
    logic [3:0] o;
    logic [31:0] x, y;
    logic u;
    int lat, el;
    logic [66:0] res, exp;
    for (int n = 0; n < 48; n++) begin
      s8 = n[0];
      o  = op_pool[$urandom_range(0, 10)];
      x  = rnd_val(s8);
      y  = rnd_val(s8);
      u  = 1'($urandom_range(0, 1));
      issue(s8, o, x, y, u, lat, res, gap);
      exp = model(s8 ? 8 : 32, o, x, y, u);
      el  = is_muldiv(o) ? (s8 ? 9 : 33) : 1;
      checks++;
      if (res !== exp) begin
        failures++;
        $display("FAIL rand[%0d] w=%0d op=%h a=%h b=%h u=%b got=%h want=%h",
                 n, s8 ? 8 : 32, o, x, y, u, res, exp);
      end
      checks++;
      if (lat !== el || gap !== 1'b0) begin
        failures++;
        $display("FAIL rand_timing[%0d] op=%h lat=%0d gap=%b want lat=%0d gap=0", n, o, lat, gap, el);
      end
    end
  endtask

  initial begin
    test_reset;
    test_addsub;
    test_muldiv;
    test_busy_drop;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
